// File: rtl/data_mem_unit.sv
// Byte-addressable word memory for the load/store stage; misaligned word-crossing accesses split into two word accesses.
// Build option DMEM_MISALIGN_TRAP_EN: misaligned accesses are rejected with resp_err instead of being split.
module data_mem_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter bit INIT_ZERO   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);
  // state | meaning
  // IDLE  | ready for a request
  // ACC1  | access word addr>>2
  // ACC2  | access the following word of a split access
  // RESP  | response held until consumed
  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_RESP} state_e;

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS) << 2;
  localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0 : 32'hx;

  logic [31:0] mem_q [DEPTH_WORDS] = '{default: INIT_WORD};

  state_e           state_q;
  logic             req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0]      resp_rdata_q;
  logic             we_q, unsigned_q, split_q;
  logic [1:0]       off_q;
  logic [2:0]       nbytes_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q, lo_q;

  logic [2:0]            req_nbytes;
  logic [ADDR_WIDTH:0]   req_last;
  logic                  range_err, req_split, acc_err;

  always_comb begin
    case (req_size)
      2'd1:    req_nbytes = 3'd2;
      2'd2:    req_nbytes = 3'd1;
      default: req_nbytes = 3'd4;
    endcase
  end

  // one extra bit so addresses near the top of the address space cannot wrap into range
  assign req_last  = {1'b0, req_addr} + (ADDR_WIDTH+1)'(req_nbytes - 3'd1);
  assign range_err = req_last >= MEM_BYTES;
  assign req_split = ({1'b0, req_addr[1:0]} + req_nbytes) > 3'd4;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (req_addr[1:0] & (req_nbytes[1:0] - 2'd1)) != 2'd0;
  assign acc_err    = range_err | misaligned;
`else
  assign acc_err    = range_err;
`endif

  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      rd_word, rd_aligned, load_val;
  logic [63:0]      rd_pair;
  logic [3:0]       lane_mask, wr_be;
  logic [7:0]       wr_be_wide;
  logic [63:0]      wr_data_wide;
  logic [31:0]      wr_data;
  logic             wr_en;

  assign acc_idx    = (state_q == S_ACC2) ? idx_q + IDX_W'(1) : idx_q;
  assign rd_word    = mem_q[acc_idx];
  assign rd_pair    = (state_q == S_ACC2) ? {rd_word, lo_q} : {32'h0, rd_word};
  assign rd_aligned = 32'(rd_pair >> {off_q, 3'b000});

  always_comb begin
    case (nbytes_q)
      3'd1:    load_val = unsigned_q ? {24'h0, rd_aligned[7:0]}
                                     : {{24{rd_aligned[7]}}, rd_aligned[7:0]};
      3'd2:    load_val = unsigned_q ? {16'h0, rd_aligned[15:0]}
                                     : {{16{rd_aligned[15]}}, rd_aligned[15:0]};
      default: load_val = rd_aligned;
    endcase
  end

  always_comb begin
    case (nbytes_q)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // lanes past 3 spill into the low lanes of the next word
  assign wr_be_wide   = {4'h0, lane_mask} << off_q;
  assign wr_data_wide = {32'h0, wdata_q} << {off_q, 3'b000};
  assign wr_be        = (state_q == S_ACC2) ? wr_be_wide[7:4] : wr_be_wide[3:0];
  assign wr_data      = (state_q == S_ACC2) ? wr_data_wide[63:32] : wr_data_wide[31:0];
  assign wr_en        = we_q && ((state_q == S_ACC1) || (state_q == S_ACC2));

  // rst_n gates the write so a reset during ACC2 abandons the second half
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[acc_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            unsigned_q  <= req_unsigned;
            split_q     <= req_split;
            off_q       <= req_addr[1:0];
            nbytes_q    <= req_nbytes;
            idx_q       <= req_addr[IDX_W+1:2];
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (acc_err) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              state_q <= S_ACC1;
            end
          end
        end
        S_ACC1: begin
          lo_q <= rd_word;
          if (split_q) begin
            state_q <= S_ACC2;
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? 32'h0 : load_val;
          end
        end
        S_ACC2: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= we_q ? 32'h0 : load_val;
        end
        default: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: directed cases plus random traffic against a byte-array reference model.
module tb_data_mem_unit;
  localparam int AW = 32;
  localparam int DW = 1024;
  localparam int NB = 4 * DW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;
  logic [7:0]  mdl [NB];
  logic [31:0] rd, exp1, exp2;

  always #5 clk = ~clk;

  data_mem_unit #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DW), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd1) ? 2 : ((sz == 2'd2) ? 1 : 4);
  endfunction

  function automatic bit mdl_err(input logic [31:0] addr, input logic [1:0] sz);
    longint last;
    bit e;
    last = longint'(addr) + longint'(nbytes(sz)) - 1;
    e = last >= longint'(NB);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((int'(addr[1:0]) % nbytes(sz)) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] addr, input logic [1:0] sz, input bit uns);
    int n;
    logic [31:0] v, m;
    n = nbytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[addr + 32'(i)];
    if (n == 4) return v;
    m = (32'h1 << (8*n)) - 32'h1;
    if (!uns && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  task automatic mdl_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] sz);
    for (int i = 0; i < nbytes(sz); i++) mdl[addr + 32'(i)] = wdata[8*i +: 8];
  endtask

  task automatic txn(input string tag, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] sz, input bit uns, output logic [31:0] rdata);
    bit exp_err;
    logic [31:0] exp_rd;
    int exp_lat, lat, w;
    exp_err = mdl_err(addr, sz);
    exp_rd  = 32'h0;
    exp_lat = exp_err ? 1 : (((int'(addr[1:0]) + nbytes(sz)) > 4) ? 3 : 2);
    if (!exp_err) begin
      if (we) mdl_store(addr, wdata, sz);
      else exp_rd = mdl_load(addr, sz, uns);
    end
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = sz; req_unsigned = uns;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    // scramble inputs after accept: the unit must use only the captured fields
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " err"}, {31'h0, resp_err}, {31'h0, exp_err});
    check({tag, " rdata"}, resp_rdata, exp_rd);
    rdata = resp_rdata;
    @(posedge clk);
    #1;
    check({tag, " retire"}, {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    for (int i = 0; i < NB; i++) mdl[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", {31'h0, req_ready}, 32'h1);
    check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset resp_err", {31'h0, resp_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    txn("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 1'b0, rd);
    txn("lw10", 1'b0, 32'h10, 32'h0, 2'd0, 1'b0, rd);
    check("lw10 value", rd, 32'hDEADBEEF);
    txn("lb13", 1'b0, 32'h13, 32'h0, 2'd2, 1'b0, rd);
    check("lb13 value", rd, 32'hFFFFFFDE);
    txn("lbu13", 1'b0, 32'h13, 32'h0, 2'd2, 1'b1, rd);
    check("lbu13 value", rd, 32'h000000DE);
    txn("lh10", 1'b0, 32'h10, 32'h0, 2'd1, 1'b0, rd);
    check("lh10 value", rd, 32'hFFFFBEEF);

    txn("sw20", 1'b1, 32'h20, 32'h11223344, 2'd0, 1'b0, rd);
    txn("sb21", 1'b1, 32'h21, 32'h000000AA, 2'd2, 1'b0, rd);
    txn("lw20 after sb", 1'b0, 32'h20, 32'h0, 2'd0, 1'b0, rd);
    check("sb lane preserve", rd, 32'h1122AA44);

    txn("sw20b", 1'b1, 32'h20, 32'h11223344, 2'd0, 1'b0, rd);
    txn("sw24", 1'b1, 32'h24, 32'h55667788, 2'd0, 1'b0, rd);
    txn("lw22 split", 1'b0, 32'h22, 32'h0, 2'd0, 1'b0, rd);
`ifndef DMEM_MISALIGN_TRAP_EN
    check("lw22 value", rd, 32'h77881122);
`endif
    txn("sh23 split", 1'b1, 32'h23, 32'h0000CAFE, 2'd1, 1'b0, rd);
    txn("lw20 after sh", 1'b0, 32'h20, 32'h0, 2'd0, 1'b0, rd);
    txn("lw24 after sh", 1'b0, 32'h24, 32'h0, 2'd0, 1'b0, exp1);
`ifndef DMEM_MISALIGN_TRAP_EN
    check("sh23 word20", rd, 32'hFE223344);
    check("sh23 word24", exp1, 32'h556677CA);
`endif

    txn("lw FFC", 1'b0, 32'hFFC, 32'h0, 2'd0, 1'b0, rd);
    txn("lw FFE", 1'b0, 32'hFFE, 32'h0, 2'd0, 1'b0, rd);
    txn("sb 1000", 1'b1, 32'h1000, 32'h0000005A, 2'd2, 1'b0, rd);
    txn("lw 0 after oob", 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, rd);
    txn("lw FFFFFFFE", 1'b0, 32'hFFFFFFFE, 32'h0, 2'd0, 1'b0, rd);

    // backpressure: response held for 5 cycles while a second request waits
    exp1 = mdl_load(32'h10, 2'd0, 1'b0);
    exp2 = mdl_load(32'h24, 2'd0, 1'b0);
    resp_ready = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; req_size = 2'd0; req_unsigned = 1'b0; req_valid = 1'b1;
    check("bp idle ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_addr = 32'h24;
    @(posedge clk);
    #1;
    check("bp resp_valid", {31'h0, resp_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold valid", {31'h0, resp_valid}, 32'h1);
      check("bp hold rdata", resp_rdata, exp1);
      check("bp hold err", {31'h0, resp_err}, 32'h0);
      check("bp hold req_ready", {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp retired", {31'h0, resp_valid}, 32'h0);
    check("bp ready after retire", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp second accepted", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("bp second valid", {31'h0, resp_valid}, 32'h1);
    check("bp second rdata", resp_rdata, exp2);
    @(posedge clk);
    #1;
    check("bp second retired", {31'h0, resp_valid}, 32'h0);

`ifndef DMEM_MISALIGN_TRAP_EN
    // reset during ACC2 of a split store: only the first word is written
    txn("sw40", 1'b1, 32'h40, 32'h11223344, 2'd0, 1'b0, rd);
    txn("sw44", 1'b1, 32'h44, 32'h55667788, 2'd0, 1'b0, rd);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h42; req_wdata = 32'hAABBCCDD; req_size = 2'd0; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst resp_valid", {31'h0, resp_valid}, 32'h0);
    check("midrst req_ready", {31'h0, req_ready}, 32'h1);
    rst_n = 1'b1;
    mdl[32'h42] = 8'hDD;
    mdl[32'h43] = 8'hCC;
    txn("midrst lw40", 1'b0, 32'h40, 32'h0, 2'd0, 1'b0, rd);
    txn("midrst lw44", 1'b0, 32'h44, 32'h0, 2'd0, 1'b0, rd);
    check("midrst word44", rd, 32'h55667788);
`endif

    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 19);
      if (sel < 15) a = 32'($urandom_range(0, 127));
      else if (sel < 18) a = 32'($urandom_range(4080, 4111));
      else a = $urandom;
      txn("rand", 1'($urandom), a, $urandom, 2'($urandom), 1'($urandom), rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
